// File: rtl/secuenciador_rtc.sv
// Transaction sequencer for the RTC parallel bus: arbitrates init/write/read requests,
// walks 16-phase byte slots and drives the mode select, slot enables and bus strobes.
module secuenciador_rtc #(
   parameter int N_INIT     = 24,
   parameter int N_ESCRIBIR = 14,
   parameter int N_LEER     = 14
) (
   input  logic       reloj,
   input  logic       resetM,
   input  logic       req_escribir,
   input  logic       tick_lectura,
   output logic [1:0] Control,
   output logic       enable_cont_16,
   output logic       enable_cont_I,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic       ad,
   output logic       dato_capt,
   output logic       ocupado,
   output logic       init_hecho
);

   localparam logic [1:0] M_INIT  = 2'd0;
   localparam logic [1:0] M_ESC   = 2'd1;
   localparam logic [1:0] M_LEC   = 2'd2;
   localparam logic [1:0] M_REPOSO = 2'd3;

   localparam logic [4:0] ULT_INIT = 5'(N_INIT - 1);
   localparam logic [4:0] ULT_ESC  = 5'(N_ESCRIBIR - 1);
   localparam logic [4:0] ULT_LEC  = 5'(N_LEER - 1);

   typedef enum logic [1:0] {REPOSO, TRANSFER, FIN} estado_t;

   estado_t    estado, estado_sig;
   logic [3:0] fase, fase_sig;
   logic [4:0] indice, indice_sig;
   logic [1:0] modo, modo_sig;
   logic [4:0] ultimo;
   logic       pend_init, pend_esc, pend_lec;
   logic       conc_init, conc_esc, conc_lec, fin_init;

   logic [1:0] control_sig;
   logic       en16_sig, activo_sig, cs_sig, wr_sig, rd_sig, ad_sig, capt_sig;
   logic       ventana, impar, lectura;

   always_comb begin
      case (modo)
         M_INIT:  ultimo = ULT_INIT;
         M_ESC:   ultimo = ULT_ESC;
         default: ultimo = ULT_LEC;
      endcase
   end

   always_comb begin
      estado_sig = estado;
      fase_sig   = fase;
      indice_sig = indice;
      modo_sig   = modo;
      conc_init  = 1'b0;
      conc_esc   = 1'b0;
      conc_lec   = 1'b0;
      fin_init   = 1'b0;
      case (estado)
         REPOSO: begin
            // Fixed priority; user transactions wait until the RTC has been initialised.
            if (pend_init) begin
               conc_init = 1'b1;
               modo_sig  = M_INIT;
            end else if (init_hecho && pend_esc) begin
               conc_esc = 1'b1;
               modo_sig = M_ESC;
            end else if (init_hecho && pend_lec) begin
               conc_lec = 1'b1;
               modo_sig = M_LEC;
            end
            if (conc_init || conc_esc || conc_lec) begin
               estado_sig = TRANSFER;
               fase_sig   = 4'd0;
               indice_sig = 5'd0;
            end
         end
         TRANSFER: begin
            fase_sig = fase + 4'd1;
            if (fase == 4'd15) begin
               if (indice == ultimo) begin
                  estado_sig = FIN;
                  fin_init   = (modo == M_INIT);
               end else begin
                  indice_sig = indice + 5'd1;
               end
            end
         end
         FIN:     estado_sig = REPOSO;
         default: estado_sig = REPOSO;
      endcase
   end

   // Outputs are decoded from the next state so the registered strobes line up with the phase counter.
   always_comb begin
      activo_sig  = (estado_sig == TRANSFER);
      ventana     = (fase_sig >= 4'd3) && (fase_sig <= 4'd10);
      impar       = indice_sig[0];
      lectura     = (modo_sig == M_LEC);
      control_sig = activo_sig ? modo_sig : M_REPOSO;
      en16_sig    = activo_sig && (fase_sig == 4'd15);
      cs_sig      = !(activo_sig && (fase_sig >= 4'd1) && (fase_sig <= 4'd14));
      ad_sig      = activo_sig ? impar : 1'b1;
      wr_sig      = !(activo_sig && ventana && !(impar && lectura));
      rd_sig      = !(activo_sig && ventana && impar && lectura);
      capt_sig    = activo_sig && lectura && impar && (fase_sig == 4'd10);
   end

   always_ff @(posedge reloj) begin
      if (resetM) begin
         estado         <= REPOSO;
         fase           <= 4'd0;
         indice         <= 5'd0;
         modo           <= M_REPOSO;
         pend_init      <= 1'b1;
         pend_esc       <= 1'b0;
         pend_lec       <= 1'b0;
         Control        <= M_REPOSO;
         enable_cont_16 <= 1'b0;
         enable_cont_I  <= 1'b0;
         cs_n           <= 1'b1;
         wr_n           <= 1'b1;
         rd_n           <= 1'b1;
         ad             <= 1'b1;
         dato_capt      <= 1'b0;
         ocupado        <= 1'b0;
         init_hecho     <= 1'b0;
      end else begin
         estado         <= estado_sig;
         fase           <= fase_sig;
         indice         <= indice_sig;
         modo           <= modo_sig;
         pend_init      <= pend_init & ~conc_init;
         pend_esc       <= req_escribir | (pend_esc & ~conc_esc);
         pend_lec       <= tick_lectura | (pend_lec & ~conc_lec);
         Control        <= control_sig;
         enable_cont_16 <= en16_sig;
         enable_cont_I  <= activo_sig;
         cs_n           <= cs_sig;
         wr_n           <= wr_sig;
         rd_n           <= rd_sig;
         ad             <= ad_sig;
         dato_capt      <= capt_sig;
         ocupado        <= activo_sig;
         if (fin_init) init_hecho <= 1'b1;
      end
   end

endmodule

// File: tb/tb_secuenciador_rtc.sv
// Directed bench for secuenciador_rtc: slot-shape vector table plus multi-transaction sequences.
module tb_secuenciador_rtc;

   logic       reloj = 1'b0;
   logic       resetM, req_escribir, tick_lectura;
   logic [1:0] Control;
   logic       enable_cont_16, enable_cont_I, cs_n, wr_n, rd_n, ad, dato_capt, ocupado, init_hecho;

   secuenciador_rtc #(.N_INIT(24), .N_ESCRIBIR(14), .N_LEER(14)) dut (
      .reloj(reloj), .resetM(resetM), .req_escribir(req_escribir), .tick_lectura(tick_lectura),
      .Control(Control), .enable_cont_16(enable_cont_16), .enable_cont_I(enable_cont_I),
      .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .ad(ad), .dato_capt(dato_capt),
      .ocupado(ocupado), .init_hecho(init_hecho)
   );

   always #5 reloj = ~reloj;

   typedef struct {
      int         c;
      logic [1:0] ctrl;
      logic       cs, wr, rd, a, dc, e16, oc;
   } vec_t;

   localparam int NT = 17;
   vec_t tbl[NT];

   int checks = 0;
   int errors = 0;
   int n_e16, n_bad_e16, n_dc, n_rdl, n_wrl, n_bad_ctrl, n_bad_ad, n_bad_oc;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge reloj);
      #1;
   endtask

   function automatic int snap();
      return int'({Control, cs_n, wr_n, rd_n, ad, dato_capt, enable_cont_16, ocupado});
   endfunction

   // Entered just after the grant edge (cycle 0 of the transaction); leaves at the FIN cycle.
   task automatic run_txn(input logic [1:0] mode, input int n, input int esc_at,
                          input int tick_at, input bit use_tbl);
      int k = 0;
      n_e16 = 0; n_bad_e16 = 0; n_dc = 0; n_rdl = 0; n_wrl = 0;
      n_bad_ctrl = 0; n_bad_ad = 0; n_bad_oc = 0;
      for (int c = 0; c < 16 * n; c++) begin
         req_escribir = (c == esc_at);
         tick_lectura = (tick_at >= 0) && (c == tick_at || c == tick_at + 3 || c == tick_at + 6);
         if (Control !== mode) n_bad_ctrl++;
         if (ocupado !== 1'b1 || enable_cont_I !== 1'b1) n_bad_oc++;
         if (ad !== 1'((c / 16) % 2)) n_bad_ad++;
         if (enable_cont_16) begin
            n_e16++;
            if (c % 16 != 15) n_bad_e16++;
         end
         if (dato_capt) n_dc++;
         if (!rd_n) n_rdl++;
         if (!wr_n) n_wrl++;
         if (use_tbl) begin
            while (k < NT && tbl[k].c == c) begin
               chk($sformatf("slot_vec_c%0d", c), snap(),
                   int'({tbl[k].ctrl, tbl[k].cs, tbl[k].wr, tbl[k].rd, tbl[k].a,
                         tbl[k].dc, tbl[k].e16, tbl[k].oc}));
               k++;
            end
         end
         step();
      end
      req_escribir = 1'b0;
      tick_lectura = 1'b0;
      if (use_tbl && k < NT && tbl[k].c == 16 * n)
         chk("slot_vec_fin", snap(),
             int'({tbl[k].ctrl, tbl[k].cs, tbl[k].wr, tbl[k].rd, tbl[k].a,
                   tbl[k].dc, tbl[k].e16, tbl[k].oc}));
   endtask

   task automatic chk_fin(input string tag, input int hecho);
      chk({tag, "_fin_ctrl"}, int'(Control), 3);
      chk({tag, "_fin_ocupado"}, int'({ocupado, enable_cont_I}), 0);
      chk({tag, "_fin_strobes"}, int'({cs_n, wr_n, rd_n}), 7);
      chk({tag, "_fin_init_hecho"}, int'(init_hecho), hecho);
   endtask

   task automatic chk_idle(input string name, input int cycles);
      int bad = 0;
      for (int i = 0; i < cycles; i++) begin
         if (Control !== 2'd3 || ocupado !== 1'b0) bad++;
         step();
      end
      chk(name, bad, 0);
   endtask

   initial begin
      // Read-mode slot shape: c = cycles since grant edge; phase = c%16, byte = c/16.
      tbl[0]  = '{0,   2'd2, 1, 1, 1, 0, 0, 0, 1};
      tbl[1]  = '{1,   2'd2, 0, 1, 1, 0, 0, 0, 1};
      tbl[2]  = '{2,   2'd2, 0, 1, 1, 0, 0, 0, 1};
      tbl[3]  = '{3,   2'd2, 0, 0, 1, 0, 0, 0, 1};
      tbl[4]  = '{10,  2'd2, 0, 0, 1, 0, 0, 0, 1};
      tbl[5]  = '{11,  2'd2, 0, 1, 1, 0, 0, 0, 1};
      tbl[6]  = '{14,  2'd2, 0, 1, 1, 0, 0, 0, 1};
      tbl[7]  = '{15,  2'd2, 1, 1, 1, 0, 0, 1, 1};
      tbl[8]  = '{16,  2'd2, 1, 1, 1, 1, 0, 0, 1};
      tbl[9]  = '{18,  2'd2, 0, 1, 1, 1, 0, 0, 1};
      tbl[10] = '{19,  2'd2, 0, 1, 0, 1, 0, 0, 1};
      tbl[11] = '{26,  2'd2, 0, 1, 0, 1, 1, 0, 1};
      tbl[12] = '{27,  2'd2, 0, 1, 1, 1, 0, 0, 1};
      tbl[13] = '{31,  2'd2, 1, 1, 1, 1, 0, 1, 1};
      tbl[14] = '{35,  2'd2, 0, 0, 1, 0, 0, 0, 1};
      tbl[15] = '{223, 2'd2, 1, 1, 1, 1, 0, 1, 1};
      tbl[16] = '{224, 2'd3, 1, 1, 1, 1, 0, 0, 0};

      resetM = 1'b1; req_escribir = 1'b0; tick_lectura = 1'b0;
      step(); step(); step();
      chk("rst_ctrl", int'(Control), 3);
      chk("rst_strobes_ad", int'({cs_n, wr_n, rd_n, ad}), 15);
      chk("rst_flags", int'({enable_cont_16, enable_cont_I, dato_capt, ocupado, init_hecho}), 0);

      // Init after reset release, with a write and three read ticks arriving meanwhile.
      resetM = 1'b0;
      step();
      chk("init_grant_ctrl", int'(Control), 0);
      chk("init_grant_busy", int'({ocupado, enable_cont_I, init_hecho}), 6);
      run_txn(2'd0, 24, 100, 200, 1'b0);
      chk("init_ctrl_stable", n_bad_ctrl, 0);
      chk("init_busy_stable", n_bad_oc, 0);
      chk("init_e16_count", n_e16, 24);
      chk("init_e16_phase", n_bad_e16, 0);
      chk("init_ad_pattern", n_bad_ad, 0);
      chk("init_wr_low", n_wrl, 192);
      chk("init_rd_low", n_rdl + n_dc, 0);
      chk_fin("init", 1);
      step();
      chk("gap_reposo_ctrl", int'(Control), 3);
      step();
      chk("write_grant_ctrl", int'(Control), 1);

      // Write, with three more read ticks that must collapse into the pending one.
      run_txn(2'd1, 14, -1, 40, 1'b0);
      chk("write_ctrl_stable", n_bad_ctrl, 0);
      chk("write_e16_count", n_e16, 14);
      chk("write_no_capt", n_dc, 0);
      chk("write_rd_low", n_rdl, 0);
      chk("write_wr_low", n_wrl, 112);
      chk("write_ad_pattern", n_bad_ad, 0);
      chk_fin("write", 1);
      step(); step();
      chk("read_grant_ctrl", int'(Control), 2);

      run_txn(2'd2, 14, -1, -1, 1'b1);
      chk("read_capt_count", n_dc, 7);
      chk("read_rd_low", n_rdl, 56);
      chk("read_wr_low", n_wrl, 56);
      chk("read_e16_count", n_e16, 14);
      step();
      chk_idle("single_read_only", 6);

      // Tick held two cycles: the second coincides with the grant and queues another read.
      tick_lectura = 1'b1;
      step();
      step();
      tick_lectura = 1'b0;
      chk("coinc_read1_ctrl", int'(Control), 2);
      run_txn(2'd2, 14, -1, -1, 1'b0);
      chk("coinc_read1_capt", n_dc, 7);
      step(); step();
      chk("coinc_read2_ctrl", int'(Control), 2);
      run_txn(2'd2, 14, -1, -1, 1'b0);
      chk("coinc_read2_capt", n_dc, 7);
      step();
      chk_idle("coinc_then_idle", 6);

      // Reset at phase 7 of byte 5 of a write.
      req_escribir = 1'b1;
      step();
      req_escribir = 1'b0;
      step();
      chk("rstmid_write_ctrl", int'(Control), 1);
      for (int i = 0; i < 87; i++) step();
      chk("rstmid_window", int'({cs_n, wr_n, ad}), 1);
      resetM = 1'b1;
      step();
      chk("rstmid_ctrl", int'(Control), 3);
      chk("rstmid_strobes_ad", int'({cs_n, wr_n, rd_n, ad}), 15);
      chk("rstmid_flags", int'({enable_cont_16, enable_cont_I, dato_capt, ocupado, init_hecho}), 0);
      resetM = 1'b0;
      step();
      chk("rstmid_init_grant", int'(Control), 0);
      run_txn(2'd0, 24, -1, -1, 1'b0);
      chk("rstmid_init_e16", n_e16, 24);
      chk("rstmid_init_ctrl", n_bad_ctrl, 0);
      chk_fin("rstmid_init", 1);
      step();
      chk_idle("rstmid_no_write_resume", 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
